// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
//   ld_state_e  : loader FSM state encoding (3 bits)
//   LdSyncByte  : default frame start marker
//   csum_add    : 8-bit modular add used by the running checksum
package prog_loader_pkg;

  typedef enum logic [2:0] {
    StSync = 3'd0,
    StLen0 = 3'd1,
    StLen1 = 3'd2,
    StData = 3'd3,
    StCsum = 3'd4,
    StRun  = 3'd5,
    StErr  = 3'd6
  } ld_state_e;

  localparam logic [7:0] LdSyncByte = 8'hA5;

  function automatic logic [7:0] csum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream link plus instruction-memory write port and CPU control of the loader.
//   master : host side (drives rx_valid/rx_data, observes everything else)
//   slave  : loader side (accepts bytes, drives memory strobe and status)
interface prog_loader_if #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error
  );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// Packs bytes little-endian into a WIDTH-bit word.
//   clk, reset    : clock, async active-high reset
//   clear         : restart at lane 0 with an empty word
//   byte_valid    : byte_data is consumed this cycle
//   word          : word register (complete once word_complete has fired)
//   word_complete : combinational pulse on the byte that fills the top lane
module prog_loader_byte_packer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic [WIDTH-1:0] word,
  output logic             word_complete
);
  localparam int unsigned BYTES = WIDTH / 8;
  localparam int unsigned IdxW  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BYTES - 1);

  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear) begin
      idx_d  = '0;
      word_d = '0;
    end else if (byte_valid) begin
      for (int unsigned b = 0; b < BYTES; b++) begin
        if (idx_q == IdxW'(b)) word_d[b*8 +: 8] = byte_data;
      end
      idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word          = word_q;
  assign word_complete = byte_valid && !clear && (idx_q == LastIdx);
endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader. Parses frames SYNC, LEN[7:0], LEN[15:8], LEN*BYTES data bytes,
// CSUM from a valid/ready byte link, writes packed words to instruction memory and holds
// the CPU in reset until a checksum-verified image is loaded.
//   clk, reset : clock, async active-high reset
//   bus        : prog_loader_if slave (rx link, memory write port, cpu_hold/status)
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_W    = 8,
  parameter logic [7:0]  SYNC_BYTE = LdSyncByte
) (
  input logic           clk,
  input logic           reset,
  prog_loader_if.slave  bus
);
  localparam logic [16:0] MaxLen = 17'd1 << ADDR_W;

  ld_state_e         state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        sum_q, sum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              ready_q, ready_d;
  logic              hold_q, done_q, err_q;

  logic             accept;
  logic             last_word;
  logic             pk_clear;
  logic             pk_valid;
  logic [WIDTH-1:0] pk_word;
  logic             pk_complete;

  assign accept    = bus.rx_valid && ready_q;
  assign pk_clear  = (state_q == StLen1) && accept;
  assign pk_valid  = (state_q == StData) && accept;
  // The address stops at the last word instead of wrapping; completion is judged on it.
  assign last_word = (17'(addr_q) + 17'd1) == {1'b0, len_q};

  prog_loader_byte_packer #(
    .WIDTH(WIDTH)
  ) u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear        (pk_clear),
    .byte_valid   (pk_valid),
    .byte_data    (bus.rx_data),
    .word         (pk_word),
    .word_complete(pk_complete)
  );

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    sum_d    = sum_q;
    addr_d   = addr_q;
    we_d     = pk_complete;
    unique case (state_q)
      StSync: if (accept && bus.rx_data == SYNC_BYTE) state_d = StLen0;
      StLen0: begin
        if (accept) begin
          len_lo_d = bus.rx_data;
          state_d  = StLen1;
        end
      end
      StLen1: begin
        if (accept) begin
          len_d  = {bus.rx_data, len_lo_q};
          sum_d  = '0;
          addr_d = '0;
          if ({1'b0, len_d} > MaxLen) state_d = StErr;
          else if (len_d == 16'd0)    state_d = StCsum;
          else                        state_d = StData;
        end
      end
      StData: begin
        if (accept) sum_d = csum_add(sum_q, bus.rx_data);
        if (we_q) begin
          if (last_word) state_d = StCsum;
          else           addr_d  = addr_q + 1'b1;
        end
      end
      StCsum: begin
        if (accept) state_d = (csum_add(sum_q, bus.rx_data) == 8'd0) ? StRun : StErr;
      end
      StRun: ;
      StErr: if (accept && bus.rx_data == SYNC_BYTE) state_d = StLen0;
      default: state_d = StSync;
    endcase
    // Registered ready: no byte is taken during a write cycle or once running.
    ready_d = (state_d != StRun) && !we_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StSync;
      len_lo_q <= '0;
      len_q    <= '0;
      sum_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      ready_q  <= 1'b0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      sum_q    <= sum_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      ready_q  <= ready_d;
      hold_q   <= (state_d != StRun);
      done_q   <= (state_d == StRun);
      err_q    <= (state_d == StErr);
    end
  end

  assign bus.rx_ready   = ready_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = pk_word;
  assign bus.cpu_hold   = hold_q;
  assign bus.load_done  = done_q;
  assign bus.load_error = err_q;
endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ADDR_W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [WIDTH-1:0]  exp_data_q[$];
  logic [7:0]        frame[$];
  logic [ADDR_W-1:0] mon_addr;
  logic [WIDTH-1:0]  mon_data;

  prog_loader_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  prog_loader #(
    .WIDTH    (WIDTH),
    .ADDR_W   (ADDR_W),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  // Scoreboard monitor: every write strobe pops one expected write.
  always @(negedge clk) begin
    if (!reset && bus.mem_we) begin
      check("rx_ready_during_we", 64'(bus.rx_ready), 64'd0);
      if (exp_addr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_addr = exp_addr_q.pop_front();
        mon_data = exp_data_q.pop_front();
        check("write_addr", 64'(bus.mem_addr), 64'(mon_addr));
        check("write_data", 64'(bus.mem_wdata), 64'(mon_data));
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    bit ok;
    int n;
    if (gap > 0) begin
      bus.rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    n = 0;
    do begin
      ok = bus.rx_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: byte %0h not accepted, got ready=0 required ready=1", b);
    end
  endtask

  task automatic send_frame(input int unsigned gap_max);
    foreach (frame[i]) send_byte(frame[i], (gap_max > 0) ? $urandom_range(gap_max, 0) : 0);
    bus.rx_valid = 1'b0;
    frame.delete();
  endtask

  task automatic idle(input int unsigned n);
    bus.rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #1;
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_hold", 64'(bus.cpu_hold), 64'd1);
    check("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_load_done", 64'(bus.load_done), 64'd0);
    check("rst_load_error", 64'(bus.load_error), 64'd0);
    check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_reset", 64'(bus.rx_ready), 64'd1);
  endtask

  task automatic check_done(input string tag);
    check({tag, "_load_done"}, 64'(bus.load_done), 64'd1);
    check({tag, "_cpu_hold"}, 64'(bus.cpu_hold), 64'd0);
    check({tag, "_load_error"}, 64'(bus.load_error), 64'd0);
    check({tag, "_pending_writes"}, 64'(exp_addr_q.size()), 64'd0);
  endtask

  initial begin
    logic [7:0] s;
    logic [7:0] b0, b1, b2, b3;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    do_reset();

    // Basic load with rx_valid held high.
    frame = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEC};
    expect_write(8'd0, 32'h12345678);
    send_frame(0);
    check_done("basic");
    check("run_rx_ready", 64'(bus.rx_ready), 64'd0);
    idle(2);

    // Garbage before sync, then a 2-word frame.
    do_reset();
    frame = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
              8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h48};
    expect_write(8'd0, 32'h11223344);
    expect_write(8'd1, 32'hAABBCCDD);
    send_frame(0);
    check_done("garbage");

    // Bad checksum, then retry without reset.
    do_reset();
    frame = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00};
    expect_write(8'd0, 32'h12345678);
    send_frame(0);
    check("badcsum_load_error", 64'(bus.load_error), 64'd1);
    check("badcsum_cpu_hold", 64'(bus.cpu_hold), 64'd1);
    check("badcsum_load_done", 64'(bus.load_done), 64'd0);
    send_byte(8'h33, 0);
    check("err_discard_error", 64'(bus.load_error), 64'd1);
    send_byte(8'hA5, 0);
    check("retry_error_cleared", 64'(bus.load_error), 64'd0);
    frame = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEC};
    expect_write(8'd0, 32'h12345678);
    send_frame(0);
    check_done("retry");

    // Length bounds: 0x0101 words is too long, zero-length loads straight to run.
    do_reset();
    frame = '{8'hA5, 8'h01, 8'h01};
    send_frame(0);
    check("len_over_error", 64'(bus.load_error), 64'd1);
    check("len_over_hold", 64'(bus.cpu_hold), 64'd1);
    idle(3);
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(0);
    check_done("len_zero");

    // Full-depth 256-word frame with random source gaps.
    do_reset();
    frame = '{8'hA5, 8'h00, 8'h01};
    s = 8'h00;
    for (int i = 0; i < 256; i++) begin
      b0 = 8'(i);
      b1 = ~b0;
      b2 = b0 ^ 8'h5A;
      b3 = 8'(i * 3);
      frame.push_back(b0);
      frame.push_back(b1);
      frame.push_back(b2);
      frame.push_back(b3);
      s = s + b0 + b1 + b2 + b3;
      expect_write(8'(i), {b3, b2, b1, b0});
    end
    frame.push_back(8'(0 - s));
    send_frame(2);
    check_done("full");

    // Async reset between edges after two data bytes.
    do_reset();
    frame = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56};
    send_frame(0);
    #3;
    reset = 1'b1;
    #1;
    check("midrst_cpu_hold", 64'(bus.cpu_hold), 64'd1);
    check("midrst_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("midrst_mem_we", 64'(bus.mem_we), 64'd0);
    check("midrst_load_done", 64'(bus.load_done), 64'd0);
    check("midrst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    frame = '{8'h34, 8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEC};
    expect_write(8'd0, 32'h12345678);
    send_frame(0);
    check_done("after_midrst");
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end
endmodule
